// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared constants, requester typedef and round-robin pointer helper
//   for the register-file access arbiter.
//   NREQ_D/M_D/N_D/W_D : default requester count, address width, register count, data width
//   reqOneHot_t        : one-hot requester vector at the default requester count
//   nextPtr            : priority pointer that follows a grant to index idx
package rf_arb_pkg;
  localparam int NREQ_D = 4;
  localparam int M_D    = 4;
  localparam int N_D    = 15;
  localparam int W_D    = 8;

  typedef logic [NREQ_D-1:0] reqOneHot_t;

  function automatic int nextPtr(input int idx, input int nreq);
    return (idx + 1) % nreq;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; picks the first requester at or
//   after ptr, wrapping modulo NREQ.
//   req : per-requester request
//   ptr : index holding highest priority this cycle
//   gnt : one-hot grant, all zero when nothing is requested
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == '0 && req[(int'(ptr) + i) % NREQ]) gnt[(int'(ptr) + i) % NREQ] = 1'b1;
    end
  end
endmodule

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: shares the register-file write port and three-address read
//   port among NREQ requesters, each port with its own round-robin pointer.
//   Optional macro RF_ARB_BYPASS_EN: a read issued alongside a write to the same
//   address returns the written data instead of the pre-write value.
//   wr_req/wr_addr/wr_data -> wr_gnt (comb), wr_err (pulse on out-of-range write)
//   rd_req/rd_addr1..3     -> rd_gnt (comb), rd_valid (tag) + rd_data1..3, two cycles later
//   rf_we/rf_waddr/rf_wdata, rf_re/rf_raddr1..3 : registered register-file commands
//   rf_rdata1..3 : register-file read data, valid the cycle after rf_re
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int M    = M_D,
  parameter int N    = N_D,
  parameter int W    = W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   wr_req,
  input  logic [NREQ*M-1:0] wr_addr,
  input  logic [NREQ*W-1:0] wr_data,
  output logic [NREQ-1:0]   wr_gnt,
  output logic              wr_err,
  input  logic [NREQ-1:0]   rd_req,
  input  logic [NREQ*M-1:0] rd_addr1,
  input  logic [NREQ*M-1:0] rd_addr2,
  input  logic [NREQ*M-1:0] rd_addr3,
  output logic [NREQ-1:0]   rd_gnt,
  output logic [NREQ-1:0]   rd_valid,
  output logic [W-1:0]      rd_data1,
  output logic [W-1:0]      rd_data2,
  output logic [W-1:0]      rd_data3,
  output logic              rf_we,
  output logic              rf_re,
  output logic [M-1:0]      rf_waddr,
  output logic [M-1:0]      rf_raddr1,
  output logic [M-1:0]      rf_raddr2,
  output logic [M-1:0]      rf_raddr3,
  output logic [W-1:0]      rf_wdata,
  input  logic [W-1:0]      rf_rdata1,
  input  logic [W-1:0]      rf_rdata2,
  input  logic [W-1:0]      rf_rdata3
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [M:0] NLIM = N[M:0];

  logic [NREQ-1:0] wrGntRaw, rdGntRaw, rdTag;
  logic [PW-1:0]   wrPtr, rdPtr, wrIdx, rdIdx;
  logic            wrXfer, rdXfer, wrBad;
  logic [M-1:0]    wrAddrSel, rdAddrSel1, rdAddrSel2, rdAddrSel3;
  logic [W-1:0]    wrDataSel;
  logic [2:0]      rdBadNow, rdBad1, rdBad2;

  function automatic logic [PW-1:0] ohIdx(input logic [NREQ-1:0] oh);
    ohIdx = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) ohIdx = PW'(i);
  endfunction

  rr_arbiter #(.NREQ(NREQ)) uWrArb (.req(wr_req), .ptr(wrPtr), .gnt(wrGntRaw));
  rr_arbiter #(.NREQ(NREQ)) uRdArb (.req(rd_req), .ptr(rdPtr), .gnt(rdGntRaw));

  // Grants are suppressed in reset so no requester believes it transferred.
  assign wr_gnt = rst_n ? wrGntRaw : '0;
  assign rd_gnt = rst_n ? rdGntRaw : '0;
  assign wrXfer = |wr_gnt;
  assign rdXfer = |rd_gnt;
  assign wrIdx  = ohIdx(wr_gnt);
  assign rdIdx  = ohIdx(rd_gnt);

  assign wrAddrSel  = wr_addr[int'(wrIdx)*M +: M];
  assign wrDataSel  = wr_data[int'(wrIdx)*W +: W];
  assign rdAddrSel1 = rd_addr1[int'(rdIdx)*M +: M];
  assign rdAddrSel2 = rd_addr2[int'(rdIdx)*M +: M];
  assign rdAddrSel3 = rd_addr3[int'(rdIdx)*M +: M];
  assign wrBad      = {1'b0, wrAddrSel} >= NLIM;
  assign rdBadNow   = {{1'b0, rdAddrSel3} >= NLIM, {1'b0, rdAddrSel2} >= NLIM, {1'b0, rdAddrSel1} >= NLIM};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rf_we    <= 1'b0;
      wr_err   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we  <= wrXfer && !wrBad;
      wr_err <= wrXfer && wrBad;
      if (wrXfer) begin
        wrPtr    <= PW'(nextPtr(int'(wrIdx), NREQ));
        rf_waddr <= wrAddrSel;
        rf_wdata <= wrDataSel;
      end
    end
  end

  // Read pipeline: issue stage (rf_re, rdTag) then return stage (rd_valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr     <= '0;
      rf_re     <= 1'b0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_raddr3 <= '0;
      rdTag     <= '0;
      rdBad1    <= '0;
      rdBad2    <= '0;
      rd_valid  <= '0;
    end else begin
      rf_re    <= rdXfer;
      rdTag    <= rd_gnt;
      rd_valid <= rdTag;
      rdBad2   <= rdBad1;
      if (rdXfer) begin
        rdPtr     <= PW'(nextPtr(int'(rdIdx), NREQ));
        rf_raddr1 <= rdAddrSel1;
        rf_raddr2 <= rdAddrSel2;
        rf_raddr3 <= rdAddrSel3;
        rdBad1    <= rdBadNow;
      end
    end
  end

`ifdef RF_ARB_BYPASS_EN
  // The register file samples the pre-write value on a same-cycle collision,
  // so remember the collision and the written data for the return stage.
  logic [2:0]   byHit;
  logic [W-1:0] byData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byHit  <= '0;
      byData <= '0;
    end else begin
      byHit  <= {3{rf_we}} & {rf_raddr3 == rf_waddr, rf_raddr2 == rf_waddr, rf_raddr1 == rf_waddr};
      byData <= rf_wdata;
    end
  end

  assign rd_data1 = rdBad2[0] ? '0 : byHit[0] ? byData : rf_rdata1;
  assign rd_data2 = rdBad2[1] ? '0 : byHit[1] ? byData : rf_rdata2;
  assign rd_data3 = rdBad2[2] ? '0 : byHit[2] ? byData : rf_rdata3;
`else
  assign rd_data1 = rdBad2[0] ? '0 : rf_rdata1;
  assign rd_data2 = rdBad2[1] ? '0 : rf_rdata2;
  assign rd_data3 = rdBad2[2] ? '0 : rf_rdata3;
`endif
endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Shares the single write port and the single three-address read port of the project register file among NREQ requesters. Write and read ports are arbitrated independently, each round-robin. Accepted accesses are issued to the register file as registered commands, and read results are returned with a one-hot requester tag. The block sits between the execution/DMA requesters and the register file. It owns every register-file control pin.

## Interface
- NREQ, 4, number of requesters
- M, 4, register address width
- N, 15, number of implemented registers (valid addresses 0..N-1)
- W, 8, data width

- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low
- wr_req  in  NREQ  per-requester write request
- wr_addr  in  NREQ*M  packed write addresses, requester i at [i*M +: M]
- wr_data  in  NREQ*W  packed write data
- wr_gnt  out  NREQ  one-hot write grant, combinational
- wr_err  out  1  pulse: accepted write had address >= N
- rd_req  in  NREQ  per-requester read request
- rd_addr1, rd_addr2, rd_addr3  in  NREQ*M each  packed read addresses
- rd_gnt  out  NREQ  one-hot read grant, combinational
- rd_valid  out  NREQ  one-hot: read result for requester i present this cycle
- rd_data1, rd_data2, rd_data3  out  W each  read results
- rf_we, rf_re  out  1  register-file write / read enable
- rf_waddr  out  M  register-file write address
- rf_raddr1, rf_raddr2, rf_raddr3  out  M  register-file read addresses
- rf_wdata  out  W  register-file write data
- rf_rdata1, rf_rdata2, rf_rdata3  in  W  register-file read data (registered inside the register file, sampled on the same edge as rf_re)

## Operation
- Handshake: a requester holds req and its payload stable until it sees gnt high. A transfer occurs at a rising edge where req&gnt. The requester may drop or change req and payload in the next cycle.
- Grant: one-hot. It selects the first requesting index at or after the port's priority pointer, with modulo-NREQ wrap. There is no grant without req. Grants are forced to 0 while rst_n is low.
- Pointer: after each transfer it moves to granted index+1, wrapping NREQ-1 to 0. It is unchanged when no transfer occurs. Separate pointers exist for the write port and the read port. Both reset to 0.
- Write issue: transfer at edge E0 loads rf_we=1, rf_waddr, and rf_wdata for exactly one cycle. If the address is >= N, rf_we stays 0 and wr_err pulses for that cycle instead.
- Read issue: transfer at E0 loads rf_re=1 and rf_raddr1..3 for one cycle. It also loads an in-flight tag holding the one-hot requester.
- Read return: the tag is delayed one more stage, so rd_valid is high for one cycle, two cycles after the transfer cycle. rd_dataK = rf_rdataK, except that a port whose address was >= N returns 0.
- Order: a write and a read accepted on the same edge are ordered write-first only under RF_ARB_BYPASS_EN (see Configuration). Otherwise the read returns the pre-write value.
- Reset mid-operation: pointers, rf_we, rf_re, in-flight tags, and wr_err clear immediately. In-flight reads are discarded; rd_valid never fires for them.
- Reset values: rf_we=0, rf_re=0, rf_waddr/rf_raddrK=0, rf_wdata=0, wr_err=0, rd_valid=0, wr_gnt=rd_gnt=0.

## Timing
- Write: accept cycle T, rf_we in T+1, register updated at end of T+1.
- Read: accept T, rf_re in T+1, rd_valid and rd_data in T+2.
- Throughput: one write and one read accepted per cycle, fully pipelined, no bubbles.
- Fairness: a continuously requesting requester waits at most NREQ-1 transfers on a port.

## Configuration
- RF_ARB_BYPASS_EN defined: the read stage compares rf_raddrK against rf_waddr while rf_we=1 in the same cycle. On a match, rd_dataK two cycles after accept returns rf_wdata. This uses a registered match flag and a registered data copy.
- RF_ARB_BYPASS_EN undefined: no comparator is built. A same-cycle collision returns the old register value.

## Structure
- Package rf_arb_pkg: default NREQ/M/N/W constants, the one-hot requester typedef, and a round-robin next-pointer function.
- Sub-module rr_arbiter (parameter NREQ; inputs req, ptr; output one-hot gnt) is instantiated once for the write port and once for the read port.

## Test plan
- Reset release, no requests -> all outputs 0. The first wr_req=4'b0100 (addr 3, data 8'hA5) gets wr_gnt=4'b0100 the same cycle, rf_we=1/rf_waddr=3/rf_wdata=8'hA5 next cycle.
- All four wr_req held high for 8 cycles -> grants 0,1,2,3,0,1,2,3 one per cycle, rf_we continuously high.
- Requester 1 reads addrs 3,0,14 after register 3 was written 8'hA5 -> rd_valid=4'b0010 exactly 2 cycles after accept, rd_data1=8'hA5.
- Requester 0 writes reg 5=8'h3C while requester 2 reads reg 5 in the same accept cycle -> 8'h3C with RF_ARB_BYPASS_EN, prior value without it.
- Write to addr 15 -> wr_gnt pulses, rf_we stays 0, wr_err=1 for one cycle. Read of addr 15 -> that rd_dataK=0.
- rst_n asserted one cycle after a read accept -> rd_valid never asserts. Pointers return to 0 and the next simultaneous requests grant requester 0.
